cordic_nco_phase_gen: RTL

Phase-generation front end for the NCO-mode CORDIC pipeline. It runs a programmable phase accumulator with a phase offset and a sample-rate divider, and folds each output phase into the first quadrant. Each sample goes out as a seeded CORDIC vector: x = gain-compensated constant, y = 0, z = 0. The target angle and the quadrant travel in the info word. The block drives stage 0 of the NCO CORDIC chain directly via `po_dv/po_info/po_x/po_y/po_z`.

---
 rtl/cordic_nco_phase_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/cordic_nco_phase_gen.sv
// Phase accumulator + divider + quadrant fold seeding stage 0 of the NCO CORDIC chain.
// Latency: one cycle from tick to po_dv; no backpressure, downstream always accepts.
module cordic_nco_phase_gen #(
  parameter int              DW    = 20,
  parameter int              AW    = 20,
  parameter logic [DW-1:0]   XINIT = 20'h26DD4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic              cfg_vld,
  input  logic [AW-1:0]     cfg_fcw,
  input  logic [AW-1:0]     cfg_poff,
  input  logic [15:0]       cfg_div,
  output logic              cfg_ack,
  output logic              po_dv,
  output logic [AW+1:0]     po_info,
  output logic [DW-1:0]     po_x,
  output logic [DW-1:0]     po_y,
  output logic [AW-1:0]     po_z
);

  logic [AW-1:0] acc;
  logic [AW-1:0] fcw_a, poff_a, fcw_p, poff_p;
  logic [15:0]   div_a, div_p, cnt;
  logic          pend;
  logic          tick;
  logic [AW-1:0] fcw_e, poff_e, ph;

  // The apply tick is timed by the old divider; step and offset already come from
  // the pending set so the acked sample is the first one on the new config.
  assign fcw_e  = pend ? fcw_p  : fcw_a;
  assign poff_e = pend ? poff_p : poff_a;
  assign tick   = en & ~phase_clr & (cnt == div_a);
  assign ph     = acc + poff_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      fcw_a   <= '0;
      poff_a  <= '0;
      div_a   <= '0;
      fcw_p   <= '0;
      poff_p  <= '0;
      div_p   <= '0;
      pend    <= 1'b0;
      cfg_ack <= 1'b0;
      po_dv   <= 1'b0;
      po_info <= '0;
      po_x    <= '0;
      po_y    <= '0;
      po_z    <= '0;
    end else begin
      po_dv   <= tick;
      cfg_ack <= tick & pend;

      if (tick) begin
        po_info <= {ph[AW-1:AW-2], 2'b00, ph[AW-3:0]};
        po_x    <= XINIT;
        po_y    <= '0;
        po_z    <= '0;
      end

      if (phase_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (tick) begin
        acc <= acc + fcw_e;
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 16'd1;
      end

      if (tick && pend) begin
        fcw_a  <= fcw_p;
        poff_a <= poff_p;
        div_a  <= div_p;
        pend   <= 1'b0;
      end

      // A capture in the apply cycle lands after the copy, so it stays pending.
      if (cfg_vld) begin
        fcw_p  <= cfg_fcw;
        poff_p <= cfg_poff;
        div_p  <= cfg_div;
        pend   <= 1'b1;
      end
    end
  end

endmodule
